// File: rtl/ip_arb_pkg.sv
// Shared types and defaults for the instruction-pointer update arbiter.
package ip_arb_pkg;

    localparam int IP_WIDTH_DEF  = 8;
    localparam int CNT_WIDTH_DEF = 8;

    typedef logic [IP_WIDTH_DEF-1:0] ip_t;

    localparam ip_t IP_RESET_DEF = 8'h00;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    // Round-robin step: after a grant the pointer names the other requester.
    function automatic pri_e pri_next(input pri_e cur, input logic grant_a, input logic grant_b);
        pri_e nxt;
        case ({grant_a, grant_b})
            2'b10:   nxt = PRI_B;
            2'b01:   nxt = PRI_A;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ip_req_slot.sv
// One-entry holding slot for an ip update request. A granted slot can
// accept a new request in the same cycle, so one requester can sustain
// one update per clock.
module ip_req_slot
    import ip_arb_pkg::*;
#(
    parameter int W = IP_WIDTH_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic [W-1:0] data,
    input  logic         grant,
    output logic         ready,
    output logic         pending,
    output logic [W-1:0] value
);

    logic         pending_r;
    logic [W-1:0] value_r;
    logic         accept_s;

    assign ready    = !pending_r || grant;
    assign accept_s = valid && ready;
    assign pending  = pending_r;
    assign value    = value_r;

    // Capture on handshake, release on grant when nothing refills the slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_r <= 1'b0;
            value_r   <= {W{1'b0}};
        end else if (accept_s) begin
            pending_r <= 1'b1;
            value_r   <= data;
        end else if (grant) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

endmodule

// File: rtl/ip_update_arbiter.sv
// Round-robin arbiter serialising ip updates from requesters A and B onto a
// single registered instruction pointer, with a saturating conflict counter.
// Optional macro IP_UPDATE_ARBITER_TRACE_EN adds simulation-only update
// tracing and input-stability checks; behaviour is otherwise identical.
module ip_update_arbiter
    import ip_arb_pkg::*;
#(
    parameter int                   IP_WIDTH  = IP_WIDTH_DEF,
    parameter int                   CNT_WIDTH = CNT_WIDTH_DEF,
    parameter logic [IP_WIDTH-1:0]  IP_RESET  = IP_WIDTH'(IP_RESET_DEF)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [IP_WIDTH-1:0]  a_ip,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [IP_WIDTH-1:0]  b_ip,
    output logic                 b_ready,
    output logic [IP_WIDTH-1:0]  ip,
    output logic                 ip_updated,
    output logic                 owner,
    output logic [CNT_WIDTH-1:0] conflicts
);

    logic                 a_pend_s;
    logic                 b_pend_s;
    logic [IP_WIDTH-1:0]  a_val_s;
    logic [IP_WIDTH-1:0]  b_val_s;
    logic                 a_grant_s;
    logic                 b_grant_s;
    logic                 both_s;

    pri_e                 pri_r;
    logic [IP_WIDTH-1:0]  ip_r;
    logic                 upd_r;
    owner_e               owner_r;
    logic [CNT_WIDTH-1:0] conf_r;

    ip_req_slot #(.W(IP_WIDTH)) u_slot_a (
        .clock   (clock),
        .reset   (reset),
        .valid   (a_valid),
        .data    (a_ip),
        .grant   (a_grant_s),
        .ready   (a_ready),
        .pending (a_pend_s),
        .value   (a_val_s)
    );

    ip_req_slot #(.W(IP_WIDTH)) u_slot_b (
        .clock   (clock),
        .reset   (reset),
        .valid   (b_valid),
        .data    (b_ip),
        .grant   (b_grant_s),
        .ready   (b_ready),
        .pending (b_pend_s),
        .value   (b_val_s)
    );

    assign both_s = a_pend_s && b_pend_s;

    // One winner per cycle: a lone pending slot wins, a tie goes to the pointer.
    always_comb begin
        a_grant_s = 1'b0;
        b_grant_s = 1'b0;
        case ({a_pend_s, b_pend_s})
            2'b10: a_grant_s = 1'b1;
            2'b01: b_grant_s = 1'b1;
            2'b11: begin
                if (pri_r == PRI_A) begin
                    a_grant_s = 1'b1;
                end else begin
                    b_grant_s = 1'b1;
                end
            end
            default: begin
                a_grant_s = 1'b0;
                b_grant_s = 1'b0;
            end
        endcase
    end

    // Priority pointer FSM: flips to the other requester after every grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pri_r <= PRI_A;
        end else begin
            pri_r <= pri_next(pri_r, a_grant_s, b_grant_s);
        end
    end

    // ip register, owner and update pulse driven by the winning slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ip_r    <= IP_RESET;
            owner_r <= OWNER_A;
            upd_r   <= 1'b0;
        end else if (a_grant_s) begin
            ip_r    <= a_val_s;
            owner_r <= OWNER_A;
            upd_r   <= 1'b1;
        end else if (b_grant_s) begin
            ip_r    <= b_val_s;
            owner_r <= OWNER_B;
            upd_r   <= 1'b1;
        end else begin
            upd_r   <= 1'b0;
        end
    end

    // Saturating count of edges at which both slots were waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conf_r <= {CNT_WIDTH{1'b0}};
        end else if (both_s && (conf_r != {CNT_WIDTH{1'b1}})) begin
            conf_r <= conf_r + CNT_WIDTH'(1'b1);
        end else begin
            conf_r <= conf_r;
        end
    end

    assign ip         = ip_r;
    assign ip_updated = upd_r;
    assign owner      = owner_r;
    assign conflicts  = conf_r;

`ifdef IP_UPDATE_ARBITER_TRACE_EN
    logic                a_stall_r;
    logic                b_stall_r;
    logic [IP_WIDTH-1:0] a_ip_prev_r;
    logic [IP_WIDTH-1:0] b_ip_prev_r;

    // Trace each update and flag requesters that change data while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_stall_r   <= 1'b0;
            b_stall_r   <= 1'b0;
            a_ip_prev_r <= {IP_WIDTH{1'b0}};
            b_ip_prev_r <= {IP_WIDTH{1'b0}};
        end else begin
            if (a_grant_s) begin
                $display("IPARB A ip=%d conflicts=%d", a_val_s, conf_r);
            end else if (b_grant_s) begin
                $display("IPARB B ip=%d conflicts=%d", b_val_s, conf_r);
            end
            if (a_stall_r && a_valid && (a_ip != a_ip_prev_r)) begin
                $error("IPARB a_ip changed while stalled");
            end
            if (b_stall_r && b_valid && (b_ip != b_ip_prev_r)) begin
                $error("IPARB b_ip changed while stalled");
            end
            a_stall_r   <= a_valid && !a_ready;
            b_stall_r   <= b_valid && !b_ready;
            a_ip_prev_r <= a_ip;
            b_ip_prev_r <= b_ip;
        end
    end
`else
    // Tracing disabled: no simulation-only logic is elaborated.
`endif

endmodule

// File: tb/tb_ip_update_arbiter.sv
// Table-driven bench for ip_update_arbiter with an update scoreboard.
module tb_ip_update_arbiter;

    logic       clock;
    logic       reset;
    logic       a_valid;
    logic [7:0] a_ip;
    logic       a_ready;
    logic       b_valid;
    logic [7:0] b_ip;
    logic       b_ready;
    logic [7:0] ip;
    logic       ip_updated;
    logic       owner;
    logic [1:0] conflicts;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       av;
        logic [7:0] ai;
        logic       bv;
        logic [7:0] bi;
        logic       ar;
        logic       br;
        logic       upd;
        logic [7:0] eip;
        logic       own;
        logic [1:0] conf;
    } vec_t;

    typedef struct {
        logic [7:0] eip;
        logic       own;
    } upd_t;

    vec_t tbl[$];
    upd_t sb[$];

    ip_update_arbiter #(
        .IP_WIDTH  (8),
        .CNT_WIDTH (2),
        .IP_RESET  (8'd0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ip       (a_ip),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_ip       (b_ip),
        .b_ready    (b_ready),
        .ip         (ip),
        .ip_updated (ip_updated),
        .owner      (owner),
        .conflicts  (conflicts)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [7:0] ai, input logic bv, input logic [7:0] bi,
                                input logic ar, input logic br, input logic upd, input logic [7:0] eip,
                                input logic own, input logic [1:0] conf);
        vec_t v;
        v.av = av; v.ai = ai; v.bv = bv; v.bi = bi;
        v.ar = ar; v.br = br; v.upd = upd; v.eip = eip; v.own = own; v.conf = conf;
        return v;
    endfunction

    // Drive one cycle from a negedge, check readies, then check post-edge state.
    task automatic apply(input vec_t v, input string tag);
        upd_t u;
        a_valid = v.av; a_ip = v.ai;
        b_valid = v.bv; b_ip = v.bi;
        #1;
        chk({tag, "_a_ready"}, a_ready, v.ar);
        chk({tag, "_b_ready"}, b_ready, v.br);
        if (v.upd) sb.push_back('{v.eip, v.own});
        @(posedge clock);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (ip_updated === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_sb_extra_update"}, 1, 0);
            end else begin
                u = sb.pop_front();
                chk({tag, "_sb_ip"}, ip, u.eip);
                chk({tag, "_sb_owner"}, owner, u.own);
            end
        end else if (sb.size() != 0) begin
            chk({tag, "_sb_missing_update"}, sb.size(), 0);
            sb.delete();
        end
        chk({tag, "_ip_updated"}, ip_updated, v.upd);
        chk({tag, "_ip"}, ip, v.eip);
        chk({tag, "_owner"}, owner, v.own);
        chk({tag, "_conflicts"}, conflicts, v.conf);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_ip = 8'd0;
        b_valid = 1'b0; b_ip = 8'd0;

        // A alone, then B alone to bring the pointer back to PRI_A
        tbl.push_back(mk(1'b1, 8'd3, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, 1'b0, 8'd3, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd9, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 2'd0));
        // contested A=1, B=2 with pointer at PRI_A
        tbl.push_back(mk(1'b1, 8'd1, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 8'd9, 1'b1, 2'd0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 2'd1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 2'd1));
        // both valid for 8 cycles, A=5 B=6, counter saturates at 3
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 2'd2));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 2'd3));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 2'd3));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 8'd5, 1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd6, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd5, 1'b0, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 2'd3));
        // B alone to return pointer to PRI_A, then identical values 7
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, 8'd8, 1'b1, 1'b1, 1'b0, 8'd5, 1'b0, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd8, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 8'd7, 1'b1, 8'd7, 1'b1, 1'b1, 1'b0, 8'd8, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd7, 1'b0, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 8'd7, 1'b1, 2'd3));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd7, 1'b1, 2'd3));

        // reset and idle
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_ip", ip, 8'd0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_conflicts", conflicts, 2'd0);
        chk("rst_ip_updated", ip_updated, 1'b0);
        chk("rst_a_ready", a_ready, 1'b1);
        chk("rst_b_ready", b_ready, 1'b1);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            apply(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'd0), $sformatf("idle%0d", i));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // A stalled behind B's grant, then asynchronous reset mid-cycle
        apply(mk(1'b1, 8'd4, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd7, 1'b1, 2'd3), "stall0");
        apply(mk(1'b1, 8'd10, 1'b1, 8'd11, 1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 2'd3), "stall1");
        a_valid = 1'b1; a_ip = 8'd10;
        #1;
        chk("stall_a_ready", a_ready, 1'b0);
        chk("stall_b_ready", b_ready, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_ip", ip, 8'd0);
        chk("async_owner", owner, 1'b0);
        chk("async_ip_updated", ip_updated, 1'b0);
        chk("async_conflicts", conflicts, 2'd0);
        chk("async_a_ready", a_ready, 1'b1);
        chk("async_b_ready", b_ready, 1'b1);
        a_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply(mk(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 2'd0), $sformatf("post_rst%0d", i));
        end
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
